aes_key_expand_seq: RTL and testbench

Iterative AES-128 key schedule that sits directly upstream of the Encrypt round datapath. It latches a 128-bit cipher key and produces round keys 0..10 at one per clock. Results go into an internal 11-entry round-key store, which the encryption datapath reads through a registered address/data port. This moves the key schedule out of Encrypt and lets one expansion be reused across many blocks.

---
 rtl/aes_key_expand_seq_if.sv | 21 ++
 rtl/aes_key_expand_seq.sv | 156 +++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_seq_if.sv
// Request/status/read-port bundle between the AES-128 key scheduler and its consumer.
// Bit numbering follows FIPS-197: bit 0 is the MSB of byte 0, so w0 = [0:31].
interface aes_key_expand_seq_if;
  logic         start;
  logic [0:127] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_addr;
  logic [0:127] rk_data;

  modport master (
    output start, key_in, rk_addr,
    input  busy, done, keys_valid, rk_data
  );

  modport slave (
    input  start, key_in, rk_addr,
    output busy, done, keys_valid, rk_data
  );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry store,
// read back through a registered address/data port.
module aes_key_expand_seq #(
  parameter int NUM_ROUNDS = 10
) (
  input logic                 clk,
  input logic                 reset,
  aes_key_expand_seq_if.slave kx
);

  localparam int NK = NUM_ROUNDS + 1;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  typedef enum logic [0:0] {IDLE = 1'b0, EXPAND = 1'b1} state_e;

  // Forward S-box, byte b lives at bits [8*b +: 8] counting from the left.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [0:31] sub_rot_word(input logic [0:31] w);
    sub_rot_word = {sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31]), sbox(w[0:7])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [0:127] work_q, work_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
  logic [0:127] rk_data_q, rk_data_d;
  logic [0:127] rk_q [0:NK-1];

  logic         wr_en_s;
  logic [3:0]   wr_idx_s;
  logic [0:127] wr_data_s;
  logic [0:31]  t_s, n0_s, n1_s, n2_s, n3_s;

  // One FIPS-197 key-expansion round on the working key.
  always_comb begin
    t_s  = sub_rot_word(work_q[96:127]) ^ {rcon(cnt_q), 24'h000000};
    n0_s = work_q[0:31]   ^ t_s;
    n1_s = work_q[32:63]  ^ n0_s;
    n2_s = work_q[64:95]  ^ n1_s;
    n3_s = work_q[96:127] ^ n2_s;
  end

  // Next-state, store write control and status for the IDLE/EXPAND FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    wr_en_s   = 1'b0;
    wr_idx_s  = cnt_q;
    wr_data_s = {n0_s, n1_s, n2_s, n3_s};
    case (state_q)
      IDLE: begin
        if (kx.start) begin
          state_d   = EXPAND;
          cnt_d     = 4'd1;
          work_d    = kx.key_in;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
          wr_en_s   = 1'b1;
          wr_idx_s  = 4'd0;
          wr_data_s = kx.key_in;
        end else begin
          state_d = IDLE;
        end
      end
      EXPAND: begin
        wr_en_s = 1'b1;
        work_d  = {n0_s, n1_s, n2_s, n3_s};
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kx.rk_addr <= LAST_IDX) begin
      rk_data_d = rk_q[kx.rk_addr];
    end else begin
      rk_data_d = 128'h0;
    end
  end

  // Control and read-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      work_q    <= 128'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      rk_data_q <= 128'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      rk_data_q <= rk_data_d;
    end
  end

  // Round-key store; contents are qualified by keys_valid, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      rk_q[wr_idx_s] <= wr_data_s;
    end
  end

  assign kx.busy       = busy_q;
  assign kx.done       = done_q;
  assign kx.keys_valid = valid_q;
  assign kx.rk_data    = rk_data_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq using FIPS-197 reference round keys.
module tb_aes_key_expand_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  aes_key_expand_seq_if kx ();

  aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .kx    (kx.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kx.done) done_cnt++;
  end

  logic [127:0] fips_rk [0:10];
  logic [127:0] key_fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] all_ones = {128{1'b1}};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_key(input logic [3:0] addr, input logic [127:0] exp, input string tag);
    kx.rk_addr = addr;
    tick();
    check_eq(tag, kx.rk_data, exp);
  endtask

  // Starts an expansion; optionally disturbs start/key_in during cycles 3..8.
  task automatic run_expansion(input logic [127:0] key, input bit disturb, input string tag);
    int n;
    int d0;
    d0 = done_cnt;
    kx.key_in = key;
    kx.start = 1'b1;
    tick();
    kx.start = 1'b0;
    check_eq({tag, "_valid_drop"}, 128'(kx.keys_valid), 128'd0);
    n = 0;
    while (kx.busy && n < 20) begin
      n++;
      if (disturb && n >= 3 && n <= 8) begin
        kx.start = 1'b1;
        kx.key_in = all_ones;
      end else begin
        kx.start = 1'b0;
        kx.key_in = key;
      end
      tick();
    end
    kx.start = 1'b0;
    check_eq({tag, "_busy_cycles"}, 128'(n), 128'd10);
    check_eq({tag, "_done"}, 128'(kx.done), 128'd1);
    check_eq({tag, "_valid"}, 128'(kx.keys_valid), 128'd1);
    tick();
    check_eq({tag, "_done_pulses"}, 128'(done_cnt - d0), 128'd1);
    check_eq({tag, "_done_low"}, 128'(kx.done), 128'd0);
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    kx.start = 1'b0;
    kx.key_in = 128'h0;
    kx.rk_addr = 4'd0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_busy", 128'(kx.busy), 128'd0);
    check_eq("rst_done", 128'(kx.done), 128'd0);
    check_eq("rst_valid", 128'(kx.keys_valid), 128'd0);
    check_eq("rst_rkdata", kx.rk_data, 128'h0);

    // FIPS-197 key
    run_expansion(key_fips, 1'b0, "fips");
    read_key(4'd1, fips_rk[1], "fips_rk1");
    read_key(4'd10, fips_rk[10], "fips_rk10");

    // All-zero key, restarting from a valid schedule
    run_expansion(128'h0, 1'b0, "zero");
    read_key(4'd0, 128'h0, "zero_rk0");
    read_key(4'd1, 128'h62636363626363636263636362636363, "zero_rk1");
    read_key(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");

    // start and key_in disturbed mid-expansion
    run_expansion(key_fips, 1'b1, "disturb");
    read_key(4'd10, fips_rk[10], "disturb_rk10");
    read_key(4'd5, fips_rk[5], "disturb_rk5");

    // Reset at the 5th EXPAND cycle
    begin
      int d0;
      d0 = done_cnt;
      kx.key_in = 128'h0;
      kx.start = 1'b1;
      tick();
      kx.start = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("abort_busy", 128'(kx.busy), 128'd0);
      check_eq("abort_done", 128'(kx.done), 128'd0);
      check_eq("abort_valid", 128'(kx.keys_valid), 128'd0);
      check_eq("abort_rkdata", kx.rk_data, 128'h0);
      repeat (12) tick();
      check_eq("abort_no_done", 128'(done_cnt - d0), 128'd0);
      check_eq("abort_idle", 128'(kx.busy), 128'd0);
    end
    run_expansion(key_fips, 1'b0, "post_abort");
    read_key(4'd10, fips_rk[10], "post_abort_rk10");

    // Restart with key 0 after a completed expansion
    run_expansion(128'h0, 1'b0, "restart");
    read_key(4'd1, 128'h62636363626363636263636362636363, "restart_rk1");

    // Out-of-range addresses, then back-to-back sweep over the FIPS schedule
    run_expansion(key_fips, 1'b0, "sweep_prep");
    read_key(4'd11, 128'h0, "addr11");
    read_key(4'd15, 128'h0, "addr15");
    for (int i = 0; i <= 10; i++) begin
      kx.rk_addr = 4'(i);
      tick();
      check_eq($sformatf("sweep_rk%0d", i), kx.rk_data, fips_rk[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
